// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared types and default widths for the MIPS data-memory arbiter
package mips_mem_pkg;
  typedef enum logic {OWN_CPU, OWN_DMA} owner_e;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int MAX_BURST_DEF = 4;
  typedef struct packed {
    logic we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;
endpackage

// File: rtl/arb_rr2.sv
// arb_rr2: two-way round-robin arbiter with a cap on consecutive grants to one master
module arb_rr2
  import mips_mem_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  localparam int CW = MAX_BURST > 1 ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] CAP = CW'(MAX_BURST - 1);
  owner_e last_owner, win;
  logic [CW-1:0] burst_cnt;
  logic prev_gnt, keep;
  // the previous owner may only keep the bus while its run is unbroken and under the cap
  always_comb begin
    keep = prev_gnt && burst_cnt < CAP;
    win = &req ? (keep ? last_owner : (last_owner == OWN_CPU ? OWN_DMA : OWN_CPU))
               : (req[0] ? OWN_CPU : OWN_DMA);
    gnt = (rst || !(|req)) ? 2'b00 : (win == OWN_CPU ? 2'b01 : 2'b10);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner <= OWN_DMA;
      burst_cnt <= '0;
      prev_gnt <= 1'b0;
    end else if (|gnt) begin
      last_owner <= win;
      burst_cnt <= (win == last_owner && prev_gnt) ? (burst_cnt == CAP ? CAP : burst_cnt + 1'b1) : '0;
      prev_gnt <= 1'b1;
    end else begin
      burst_cnt <= '0;
      prev_gnt <= 1'b0;
    end
  end
endmodule

// File: rtl/mips_dmem_arbiter.sv
// mips_dmem_arbiter: shares the single-port data memory between the CPU and the DMA/loader
module mips_dmem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = DATA_W,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  cpu_stall
);
  logic [1:0] gnt;
  logic rd_pend;
  owner_e rd_owner;
  arb_rr2 #(.MAX_BURST(MAX_BURST)) u_arb (
    .clk(clk),
    .rst(rst),
    .req({m1_req, m0_req}),
    .gnt(gnt)
  );
  // responses are masked during reset so a pending read never escapes
  always_comb begin
    m0_gnt = gnt[0];
    m1_gnt = gnt[1];
    mem_en = |gnt;
    mem_we = gnt[0] ? m0_we : gnt[1] & m1_we;
    mem_addr = gnt[0] ? m0_addr : (gnt[1] ? m1_addr : '0);
    mem_wdata = gnt[0] ? m0_wdata : (gnt[1] ? m1_wdata : '0);
    m0_rvalid = rd_pend && !rst && rd_owner == OWN_CPU;
    m1_rvalid = rd_pend && !rst && rd_owner == OWN_DMA;
    m0_rdata = m0_rvalid ? mem_rdata : '0;
    m1_rdata = m1_rvalid ? mem_rdata : '0;
    cpu_stall = m0_req && !m0_gnt && !rst;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend <= 1'b0;
      rd_owner <= OWN_CPU;
    end else begin
      rd_pend <= mem_en && !mem_we;
      rd_owner <= gnt[1] ? OWN_DMA : OWN_CPU;
    end
  end
endmodule

// File: tb/tb_mips_dmem_arbiter.sv
// tb_mips_dmem_arbiter: directed checks of grant order, muxing, response routing and reset
module tb_mips_dmem_arbiter;
  logic clk = 0, rst = 1;
  logic m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [15:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic a_m0_gnt, a_m0_rvalid, a_m1_gnt, a_m1_rvalid, a_mem_en, a_mem_we, a_cpu_stall;
  logic [15:0] a_m0_rdata, a_m1_rdata, a_mem_addr, a_mem_wdata;
  logic [15:0] a_mem_rdata = 0;
  logic b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid, b_mem_en, b_mem_we, b_cpu_stall;
  logic [15:0] b_m0_rdata, b_m1_rdata, b_mem_addr, b_mem_wdata;
  logic [15:0] b_mem_rdata = 0;
  int total = 0, passed = 0;

  mips_dmem_arbiter #(.MAX_BURST(4)) dut_a (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(a_m0_gnt), .m0_rvalid(a_m0_rvalid), .m0_rdata(a_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(a_m1_gnt), .m1_rvalid(a_m1_rvalid), .m1_rdata(a_m1_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata), .cpu_stall(a_cpu_stall)
  );

  mips_dmem_arbiter #(.MAX_BURST(1)) dut_b (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .cpu_stall(b_cpu_stall)
  );

  always #5 clk = ~clk;

  // read-only memory image: 0x0010 holds 0xBEEF, every other word is 0xA000|addr
  always @(posedge clk)
    if (a_mem_en && !a_mem_we)
      a_mem_rdata <= (a_mem_addr == 16'h0010) ? 16'hBEEF : (16'hA000 | a_mem_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else passed++;
  endtask

  task automatic drive(input logic r0, w0, input logic [15:0] ad0, d0,
                       input logic r1, w1, input logic [15:0] ad1, d1);
    @(negedge clk);
    m0_req = r0; m0_we = w0; m0_addr = ad0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = ad1; m1_wdata = d1;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    @(negedge clk);
    rst = 0;
    #1;
  endtask

  initial begin
    int d;
    logic cpu_done;
    logic g0, g1;
    // reset with both masters requesting: nothing may leak out
    @(negedge clk);
    rst = 1; m0_req = 1; m1_req = 1; m0_addr = 16'h0020; m1_addr = 16'h0030;
    #1;
    chk("rst_en", a_mem_en, 0);
    chk("rst_gnt", {a_m1_gnt, a_m0_gnt}, 0);
    chk("rst_stall", a_cpu_stall, 0);
    chk("rst_rvalid", {a_m1_rvalid, a_m0_rvalid}, 0);
    chk("rst_addr", a_mem_addr, 0);
    @(negedge clk);
    rst = 0; m0_req = 0; m1_req = 0; m0_addr = 0; m1_addr = 0;
    #1;
    // CPU-only read
    drive(1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0);
    chk("t1_gnt0", a_m0_gnt, 1);
    chk("t1_en", a_mem_en, 1);
    chk("t1_we", a_mem_we, 0);
    chk("t1_addr", a_mem_addr, 16'h0010);
    chk("t1_stall", a_cpu_stall, 0);
    idle();
    chk("t1_rv0", a_m0_rvalid, 1);
    chk("t1_rd0", a_m0_rdata, 16'hBEEF);
    chk("t1_rv1", a_m1_rvalid, 0);
    chk("t1_rd1", a_m1_rdata, 0);
    chk("t1_en_idle", a_mem_en, 0);
    // continuous contention with MAX_BURST=4: CPU x4 then DMA x4
    do_reset();
    for (int i = 0; i < 9; i++) begin
      if (i < 8) drive(1, 0, 16'h0020, 16'h0, 1, 0, 16'h0030, 16'h0);
      else idle();
      chk("t2_gnt0", a_m0_gnt, i < 4);
      chk("t2_gnt1", a_m1_gnt, i >= 4 && i < 8);
      chk("t2_stall", a_cpu_stall, i >= 4 && i < 8);
      chk("t2_addr", a_mem_addr, i < 4 ? 16'h0020 : (i < 8 ? 16'h0030 : 16'h0));
      chk("t2_rv0", a_m0_rvalid, i >= 1 && i <= 4);
      chk("t2_rv1", a_m1_rvalid, i >= 5);
      chk("t2_rd0", a_m0_rdata, (i >= 1 && i <= 4) ? 16'hA020 : 16'h0);
      chk("t2_rd1", a_m1_rdata, i >= 5 ? 16'hA030 : 16'h0);
    end
    // DMA write stream, CPU read joins on the third beat and waits out the burst cap
    d = 0;
    cpu_done = 0;
    for (int c = 0; c < 10; c++) begin
      drive(c >= 2 && !cpu_done, 0, 16'h0040, 16'h0,
            d < 8, 1, 16'(16'h0100 + d), 16'(16'h5500 + d));
      g0 = c == 4;
      g1 = c <= 3 || (c >= 5 && c <= 8);
      chk("t3_gnt0", a_m0_gnt, g0);
      chk("t3_gnt1", a_m1_gnt, g1);
      chk("t3_stall", a_cpu_stall, c == 2 || c == 3);
      chk("t3_addr", a_mem_addr, c <= 3 ? 16'(16'h0100 + c) : (c == 4 ? 16'h0040 : (c <= 8 ? 16'(16'h00FF + c) : 16'h0)));
      chk("t3_wdata", a_mem_wdata, c <= 3 ? 16'(16'h5500 + c) : ((c >= 5 && c <= 8) ? 16'(16'h54FF + c) : 16'h0));
      chk("t3_rv0", a_m0_rvalid, c == 5);
      chk("t3_rd0", a_m0_rdata, c == 5 ? 16'hA040 : 16'h0);
      if (a_m1_gnt) d++;
      if (a_m0_gnt) cpu_done = 1;
    end
    // CPU read then DMA write: response overlaps the write cleanly
    drive(1, 0, 16'h0050, 16'h0, 0, 0, 16'h0, 16'h0);
    chk("t4_gnt0", a_m0_gnt, 1);
    drive(0, 0, 16'h0, 16'h0, 1, 1, 16'h0060, 16'h1234);
    chk("t4_gnt1", a_m1_gnt, 1);
    chk("t4_en", a_mem_en, 1);
    chk("t4_we", a_mem_we, 1);
    chk("t4_addr", a_mem_addr, 16'h0060);
    chk("t4_wdata", a_mem_wdata, 16'h1234);
    chk("t4_rv0", a_m0_rvalid, 1);
    chk("t4_rd0", a_m0_rdata, 16'hA050);
    chk("t4_rv1", a_m1_rvalid, 0);
    idle();
    chk("t4_rv_after", {a_m1_rvalid, a_m0_rvalid}, 0);
    // reset right after a granted read drops the response
    drive(1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0);
    chk("t5_gnt0", a_m0_gnt, 1);
    @(negedge clk);
    rst = 1;
    m0_addr = 16'h0020; m1_req = 1; m1_we = 0; m1_addr = 16'h0030;
    #1;
    chk("t5_rv0", a_m0_rvalid, 0);
    chk("t5_rd0", a_m0_rdata, 0);
    chk("t5_rv1", a_m1_rvalid, 0);
    chk("t5_en", a_mem_en, 0);
    chk("t5_gnt", {a_m1_gnt, a_m0_gnt}, 0);
    chk("t5_stall", a_cpu_stall, 0);
    chk("t5_addr", a_mem_addr, 0);
    @(negedge clk);
    rst = 0;
    #1;
    chk("t5_tie_gnt0", a_m0_gnt, 1);
    chk("t5_tie_gnt1", a_m1_gnt, 0);
    chk("t5_rv0_post", a_m0_rvalid, 0);
    idle();
    chk("t5_rv0_new", a_m0_rvalid, 1);
    chk("t5_rd0_new", a_m0_rdata, 16'hA020);
    chk("t5_rv1_new", a_m1_rvalid, 0);
    // MAX_BURST=1: strict alternation of writes
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1, 1, 16'h0070, 16'hC0C0, 1, 1, 16'h0080, 16'hD0D0);
      chk("t6_gnt0", b_m0_gnt, i % 2 == 0);
      chk("t6_gnt1", b_m1_gnt, i % 2 == 1);
      chk("t6_we", b_mem_we, 1);
      chk("t6_addr", b_mem_addr, i % 2 == 0 ? 16'h0070 : 16'h0080);
      chk("t6_wdata", b_mem_wdata, i % 2 == 0 ? 16'hC0C0 : 16'hD0D0);
    end
    idle();
    chk("t6_rv", {b_m1_rvalid, b_m0_rvalid}, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
